turbo_itl_buf: RTL and testbench

Ping-pong interleaver buffer for the HPGP turbo encoder path. It accepts a block of BLK_LEN symbols in natural order and stores them in one of two banks. It then emits the block in permuted order, driving the sequential read address of the interleaver address ROM and using the returned address as its buffer read index. It sits between the PB/scrambler symbol stream and the constituent encoder that takes interleaved input.

---
 rtl/turbo_itl_buf.sv | 131 +++++++++++++
 tb/tb_turbo_itl_buf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_itl_buf.sv
// Ping-pong interleaver buffer: blocks are written in natural order into one bank
// and read out through the external interleaver address ROM from the other bank.
module turbo_itl_buf #(
  parameter int D_WIDTH = 2,
  parameter int A_WIDTH = 10,
  parameter int BLK_LEN = 544
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  output logic [A_WIDTH-1:0] rom_raddr,
  input  logic [A_WIDTH-1:0] rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last,
  output logic               itl_err
);

  localparam int MEM_DEPTH = 2 * BLK_LEN;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam logic [A_WIDTH-1:0] LAST_IDX    = A_WIDTH'(BLK_LEN - 1);
  localparam logic [A_WIDTH:0]   BLK_LEN_EXT = (A_WIDTH + 1)'(BLK_LEN);

  // Both banks share one array; bank 1 starts at offset BLK_LEN.
  logic [D_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [A_WIDTH-1:0] r_wr_cnt;
  logic [A_WIDTH-1:0] r_rd_cnt;
  logic               r_out_valid;
  logic               r_out_last;
  logic [D_WIDTH-1:0] r_out_data;
  logic               r_itl_err;

  logic               w_in_ready;
  logic               w_wr_en;
  logic               w_wr_wrap;
  logic               w_adv;
  logic               w_rd_wrap;
  logic               w_addr_bad;
  logic [A_WIDTH:0]   w_wr_sum;
  logic [A_WIDTH:0]   w_rd_sum;
  logic [MEM_AW-1:0]  w_wr_addr;
  logic [MEM_AW-1:0]  w_rd_addr;
  logic [1:0]         w_full_next;

  assign w_in_ready = !r_full[r_wr_bank];
  assign w_wr_en    = in_valid && w_in_ready;
  assign w_wr_wrap  = w_wr_en && (r_wr_cnt == LAST_IDX);

  assign w_adv      = r_full[r_rd_bank] && (!r_out_valid || out_ready);
  assign w_rd_wrap  = w_adv && (r_rd_cnt == LAST_IDX);
  assign w_addr_bad = ({1'b0, rom_data} >= BLK_LEN_EXT);

  assign w_wr_sum  = {1'b0, r_wr_cnt} + (r_wr_bank ? BLK_LEN_EXT : '0);
  assign w_rd_sum  = {1'b0, rom_data} + (r_rd_bank ? BLK_LEN_EXT : '0);
  assign w_wr_addr = MEM_AW'(w_wr_sum);
  assign w_rd_addr = MEM_AW'(w_rd_sum);

  // A bank can only be set while empty and cleared while full, so set wins trivially.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign w_full_next[gi] = (w_wr_wrap && (r_wr_bank == 1'(gi))) ? 1'b1 :
                             (w_rd_wrap && (r_rd_bank == 1'(gi))) ? 1'b0 :
                             r_full[gi];
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_itl_err   <= 1'b0;
    end else begin
      r_full <= w_full_next;

      if (w_wr_en) begin
        if (w_wr_wrap) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= !r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end

      if (w_adv) begin
        r_out_valid <= 1'b1;
        r_out_last  <= (r_rd_cnt == LAST_IDX);
        // Out-of-range permuted address yields a zero symbol and a sticky error.
        if (w_addr_bad) begin
          r_out_data <= '0;
          r_itl_err  <= 1'b1;
        end else begin
          r_out_data <= r_mem[w_rd_addr];
        end
        if (w_rd_wrap) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= !r_rd_bank;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign rom_raddr = r_rd_cnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign itl_err   = r_itl_err;

endmodule

// File: tb/tb_turbo_itl_buf.sv
// Directed bench for turbo_itl_buf with BLK_LEN=8 and a small in-bench ROM table.
module tb_turbo_itl_buf;
  localparam int DW = 3;
  localparam int AW = 4;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic          itl_err;
  logic [DW-1:0] out_data;
  logic [AW-1:0] rom_raddr;
  logic [AW-1:0] rom_data;

  logic [AW-1:0] rom_tbl [16];
  logic [DW-1:0] blk [BL];

  int tests = 0;
  int fails = 0;
  int stalls = 0;
  int cyc = 0;
  logic [DW:0] got_q [$];
  int          got_cyc [$];
  logic [DW:0] exp_q [$];

  always #5 clk = ~clk;
  assign rom_data = rom_tbl[rom_raddr];

  turbo_itl_buf #(.D_WIDTH(DW), .A_WIDTH(AW), .BLK_LEN(BL)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rom_raddr(rom_raddr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .itl_err(itl_err)
  );

  // Record every output handshake with the cycle it happened in.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!n_rst && out_valid && out_ready) begin
      got_q.push_back({out_last, out_data});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_out(input int k);
    if (rom_tbl[k] >= AW'(BL)) return '0;
    return blk[rom_tbl[k]];
  endfunction

  task automatic push_exp();
    for (int k = 0; k < BL; k++) exp_q.push_back({(k == BL - 1), exp_out(k)});
  endtask

  task automatic clear_q();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
  endtask

  task automatic feed(input int n, input bit rnd);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n) begin
      in_data  = blk[i];
      in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
      if (guard > 1000) begin
        tests++; fails++;
        $display("FAIL feed_timeout: observed %0d accepted expected %0d", i, n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n, input bit rnd);
    int guard = 0;
    while (got_q.size() < n && guard < 5000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    check("drain_count", got_q.size(), n);
  endtask

  task automatic compare_all(input string tag);
    while (exp_q.size() > 0 && got_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic check_direct(input string tag);
    int guard = 0;
    logic err_exp = 1'b0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    for (int k = 0; k < BL; k++) begin
      if (rom_tbl[k] >= AW'(BL)) err_exp = 1'b1;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, exp_out(k));
      check({tag, "_last"}, out_last, (k == BL - 1));
      check({tag, "_err"}, itl_err, err_exp);
      check({tag, "_raddr"}, rom_raddr, (k + 1) % BL);
      @(posedge clk); #1;
    end
    check({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    int gaps;
    int idx;
    logic [DW:0] held;

    for (int i = 0; i < 16; i++) rom_tbl[i] = '0;
    rom_tbl[0] = 3; rom_tbl[1] = 6; rom_tbl[2] = 1; rom_tbl[3] = 4;
    rom_tbl[4] = 7; rom_tbl[5] = 2; rom_tbl[6] = 5; rom_tbl[7] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_itl_err", itl_err, 0);
    check("rst_rom_raddr", rom_raddr, 0);

    // Basic permutation and first-block latency
    clear_q();
    out_ready = 1'b1;
    for (int i = 0; i < BL; i++) blk[i] = DW'(i);
    feed(BL, 1'b0);
    lat = BL;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("basic_latency", lat, BL + 1);
    check_direct("basic");

    // Back-to-back blocks
    do_reset();
    clear_q();
    stalls = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < BL; i++) blk[i] = DW'(b * BL + i);
      push_exp();
      feed(BL, 1'b0);
    end
    drain(3 * BL, 1'b0);
    gaps = 0;
    for (int j = 1; j < got_cyc.size(); j++) if (got_cyc[j] - got_cyc[j-1] != 1) gaps++;
    check("b2b_gaps", gaps, 0);
    check("b2b_in_stalls", stalls, 0);
    compare_all("b2b_data");

    // Backpressure
    do_reset();
    clear_q();
    out_ready = 1'b1;
    for (int i = 0; i < BL; i++) blk[i] = DW'($urandom_range(0, 7));
    push_exp();
    feed(BL, 1'b0);
    lat = 0;
    while (got_q.size() < 2 && lat < 50) begin @(posedge clk); #1; lat++; end
    out_ready = 1'b0;
    idx = got_q.size();
    held = exp_q[idx];
    for (int i = 0; i < BL; i++) blk[i] = DW'($urandom_range(0, 7));
    push_exp();
    feed(BL, 1'b0);
    for (int i = 0; i < BL; i++) blk[i] = DW'($urandom_range(0, 7));
    in_data = blk[0];
    in_valid = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_hold", {out_last, out_data}, held);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    push_exp();
    feed(BL, 1'b0);
    drain(3 * BL, 1'b0);
    compare_all("bp_data");

    // Random stalls over 50 blocks
    do_reset();
    clear_q();
    for (int b = 0; b < 50; b++) begin
      for (int i = 0; i < BL; i++) blk[i] = DW'($urandom_range(0, 7));
      push_exp();
      feed(BL, 1'b1);
    end
    drain(50 * BL, 1'b1);
    compare_all("rnd_data");
    check("rnd_itl_err", itl_err, 0);

    // Bad ROM entry
    do_reset();
    clear_q();
    rom_tbl[5] = 9;
    out_ready = 1'b1;
    for (int i = 0; i < BL; i++) blk[i] = DW'(7 - i);
    feed(BL, 1'b0);
    check_direct("badrom");
    repeat (3) @(posedge clk);
    #1 check("badrom_sticky", itl_err, 1);
    rom_tbl[5] = 2;

    // Reset mid-block
    do_reset();
    check("mid_err_cleared", itl_err, 0);
    clear_q();
    out_ready = 1'b1;
    for (int i = 0; i < BL; i++) blk[i] = DW'($urandom_range(0, 7));
    feed(BL, 1'b0);
    for (int i = 0; i < BL; i++) blk[i] = DW'($urandom_range(0, 7));
    feed(5, 1'b0);
    check("mid_pre_valid", out_valid, 1);
    do_reset();
    check("mid_out_valid", out_valid, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_rom_raddr", rom_raddr, 0);
    check("mid_out_last", out_last, 0);
    for (int i = 0; i < BL; i++) blk[i] = DW'((i * 5 + 1) % 8);
    feed(BL, 1'b0);
    check_direct("mid_fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
